temp_uart_packetizer: RTL and testbench
=======================================

TEMP_UART_PACKETIZER -- requirements
Module: temp_uart_packetizer

Interface
REQ-001 Parameter DATA_DEPTH, default 8, sets the width of FIFO data bytes; only the value 8 is supported.
REQ-002 Parameter CLKS_PER_BIT, default 16, sets the number of i_clk cycles per UART bit; legal values are 2 and above.
REQ-003 Parameter HEADER, default 8'hA5, is the first byte of every packet.
REQ-004 i_clk  input  1  is the single clock; all logic is rising-edge.
REQ-005 i_rst  input  1  is the reset, asynchronous and active-low.
REQ-006 i_fifo_data  input  DATA_DEPTH  is the head byte of the upstream sample FIFO.
REQ-007 i_fifo_data_valid  input  1  is high when i_fifo_data holds a byte available to pop.
REQ-008 o_fifo_data_extracted  output  1  is a one-cycle pop strobe; the byte is consumed on that edge.
REQ-009 o_tx  output  1  is the UART serial line, 8N1, LSB first, idle high.
REQ-010 o_busy  output  1  is high in every state except IDLE.
REQ-011 o_pkt_done  output  1  is a one-cycle pulse in the cycle after the last stop bit of a packet ends.

Function
REQ-012 The packet is HEADER, INT, FRAC, then CHK; INT is the first popped byte, FRAC is the second, and CHK = HEADER ^ INT ^ FRAC.
REQ-013 The states are IDLE, FETCH_INT, FETCH_FRAC, START, DATA, STOP and DONE; IDLE moves to FETCH_INT unconditionally.
REQ-014 In FETCH_INT and FETCH_FRAC, o_fifo_data_extracted = i_fifo_data_valid, combinationally.
REQ-015 On the edge where o_fifo_data_extracted is high, the block registers i_fifo_data and advances state.
REQ-016 o_fifo_data_extracted is low in all other states.
REQ-017 If the FIFO is empty in FETCH_INT or FETCH_FRAC, the block waits indefinitely with o_tx=1 and no timeout; the INT byte already captured is retained.
REQ-018 FETCH_FRAC moves to START for byte index 0 on the capture edge, so the start bit drives o_tx on the next cycle.
REQ-019 START drives o_tx=0 for CLKS_PER_BIT cycles.
REQ-020 DATA drives bits 0..7 of the current byte, each for CLKS_PER_BIT cycles.
REQ-021 STOP drives o_tx=1 for CLKS_PER_BIT cycles.
REQ-022 After STOP, if bytes remain, the block moves directly to START for the next byte, with no idle gap between bytes.
REQ-023 After STOP of the last byte, the block moves to DONE; DONE asserts o_pkt_done for one cycle and returns to IDLE.
REQ-024 The bit timer is an up-counter of width $clog2(CLKS_PER_BIT) that wraps at CLKS_PER_BIT-1.
REQ-025 A 3-bit bit-index counter and a 2-bit byte-index counter reset on each START and packet start respectively.
REQ-026 o_tx is driven from a register (glitch-free).
REQ-027 A packet of N bytes occupies exactly N*10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-028 FIFO bytes arriving during transmission are not popped until the next FETCH_INT.

Reset
REQ-029 When i_rst=0, outputs take these values immediately and asynchronously: o_tx=1, o_busy=0, o_pkt_done=0, o_fifo_data_extracted=0.
REQ-030 During reset the state is IDLE, and all counters and byte registers are cleared to 0.
REQ-031 Reset mid-frame aborts the packet with no partial recovery; a byte popped but not fully sent is lost.
REQ-032 After reset release, the first FETCH_INT occurs 1 cycle later.

Configuration
REQ-033 When macro PACKETIZER_CHECKSUM_EN is defined, packets are 4 bytes and include CHK.
REQ-034 When PACKETIZER_CHECKSUM_EN is undefined, packets are 3 bytes (HEADER, INT, FRAC), the CHK logic is absent, and DONE follows the stop bit of FRAC.

Verification
REQ-035 With CLKS_PER_BIT=4 and PACKETIZER_CHECKSUM_EN defined, FIFO bytes 0x19 then 0x80 give o_tx bytes A5,19,80,3C over 160 cycles, then an o_pkt_done pulse.
REQ-036 With the same bytes and PACKETIZER_CHECKSUM_EN undefined, o_tx gives A5,19,80 over 120 cycles, then o_pkt_done.
REQ-037 Supplying 0x19, then holding valid low for 50 cycles, then supplying 0x80 gives o_tx=1 and o_busy=1 throughout the gap, then the normal packet; exactly 2 pop strobes occur.
REQ-038 Asserting i_rst=0 during DATA of the INT byte forces o_tx=1 in the same cycle; after release with FIFO bytes 0x00,0x00, the next packet is A5,00,00,A5.
REQ-039 With 4 bytes preloaded (0x01,0x02,0x03,0x04), two back-to-back packets are sent and o_fifo_data_extracted stays low during serialization.
REQ-040 With CLKS_PER_BIT=2, every bit of the first packet lasts exactly 2 cycles.

Source files
------------

// File: rtl/temp_uart_packetizer.sv
// Pops INT and FRAC from an upstream FIFO and sends HEADER, INT, FRAC (and CHK when
// PACKETIZER_CHECKSUM_EN is defined) as 8N1 UART bytes. States: IDLE | FETCH_INT/FETCH_FRAC pop | START/DATA/STOP serialize | DONE pulse.
module temp_uart_packetizer #(
  parameter int          DATA_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_DEPTH-1:0] i_fifo_data,
  input  logic                  i_fifo_data_valid,
  output logic                  o_fifo_data_extracted,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_pkt_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
`ifdef PACKETIZER_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  typedef enum logic [2:0] {
    IDLE, FETCH_INT, FETCH_FRAC, START, DATA, STOP, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [DATA_DEPTH-1:0] int_q, int_d;
  logic [DATA_DEPTH-1:0] frac_q, frac_d;
  logic                  tx_q, tx_d;
  logic                  extract;
  logic                  bit_done;
  logic [DATA_DEPTH-1:0] cur_byte;

  assign bit_done = (timer_q == T_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      int_q      <= '0;
      frac_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      tx_q       <= tx_d;
    end
  end

  // Byte selected by the index being entered, so tx_q lines up with state_q.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx_d)
      2'd0:    cur_byte = HEADER;
      2'd1:    cur_byte = int_q;
      2'd2:    cur_byte = frac_q;
`ifdef PACKETIZER_CHECKSUM_EN
      default: cur_byte = HEADER ^ int_q ^ frac_q;
`else
      default: cur_byte = HEADER;
`endif
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    int_d      = int_q;
    frac_d     = frac_q;
    extract    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = FETCH_INT;
        byte_idx_d = '0;
      end
      FETCH_INT: begin
        extract = i_fifo_data_valid;
        if (i_fifo_data_valid) begin
          int_d   = i_fifo_data;
          state_d = FETCH_FRAC;
        end
      end
      FETCH_FRAC: begin
        extract = i_fifo_data_valid;
        if (i_fifo_data_valid) begin
          frac_d     = i_fifo_data;
          state_d    = START;
          timer_d    = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            bit_idx_d  = '0;
            state_d    = START;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx                  = tx_q;
  assign o_busy                = (state_q != IDLE);
  assign o_pkt_done            = (state_q == DONE);
  assign o_fifo_data_extracted = extract;

endmodule

// File: tb/tb_temp_uart_packetizer.sv
// Directed bench for temp_uart_packetizer: a CLKS_PER_BIT=4 instance fed from a queue
// FIFO model, plus a CLKS_PER_BIT=2 instance checked for exact bit timing.
module tb_temp_uart_packetizer;

`ifdef PACKETIZER_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [7:0] fifo_data, fifo_data2;
  logic       fifo_valid, fifo_valid2;
  logic       ext, tx, busy, done;
  logic       ext2, tx2, busy2, done2;

  logic [7:0] fifo_q [$];
  logic       tx_s, busy_s, done_s, ext_s;
  logic       tx2_s, busy2_s, done2_s, ext2_s;
  int         pops;
  int         last_wait;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  temp_uart_packetizer #(.DATA_DEPTH(8), .CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_fifo_data(fifo_data), .i_fifo_data_valid(fifo_valid),
    .o_fifo_data_extracted(ext), .o_tx(tx), .o_busy(busy), .o_pkt_done(done)
  );

  temp_uart_packetizer #(.DATA_DEPTH(8), .CLKS_PER_BIT(2), .HEADER(8'hA5)) dut2 (
    .i_clk(clk), .i_rst(rst2_n), .i_fifo_data(fifo_data2), .i_fifo_data_valid(fifo_valid2),
    .o_fifo_data_extracted(ext2), .o_tx(tx2), .o_busy(busy2), .o_pkt_done(done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_valid = (fifo_q.size() > 0);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: sample outputs mid-cycle, then model the pop on the edge.
  task automatic cyc();
    @(negedge clk);
    tx_s = tx;   busy_s = busy;   done_s = done;   ext_s = ext;
    tx2_s = tx2; busy2_s = busy2; done2_s = done2; ext2_s = ext2;
    @(posedge clk);
    #1;
    if (ext_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  task automatic recv_pkt(input string tag, input int which, input int cpb,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] pkt [4];
    logic [9:0] frame;
    logic       t;
    int         glitch, ext_hi, busy_lo, w;
    pkt[0] = b0; pkt[1] = b1; pkt[2] = b2; pkt[3] = b3;
    glitch = 0; ext_hi = 0; busy_lo = 0; w = 0;
    do begin
      cyc();
      w++;
      t = (which == 1) ? tx2_s : tx_s;
    end while (t !== 1'b0 && w < 200);
    last_wait = w;
    if (t !== 1'b0) begin
      check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < NB; k++) begin
      frame = '0;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < cpb; c++) begin
          if (!(k == 0 && i == 0 && c == 0)) cyc();
          t = (which == 1) ? tx2_s : tx_s;
          if (c == 0) frame[i] = t;
          else if (t !== frame[i]) glitch++;
          if (((which == 1) ? ext2_s : ext_s) !== 1'b0) ext_hi++;
          if (((which == 1) ? busy2_s : busy_s) !== 1'b1) busy_lo++;
        end
      end
      check_eq($sformatf("%s_byte%0d", tag, k), {22'd0, frame}, {22'd0, 1'b1, pkt[k], 1'b0});
    end
    check_eq({tag, "_bit_width"}, glitch, 0);
    check_eq({tag, "_no_pop_in_tx"}, ext_hi, 0);
    check_eq({tag, "_busy_in_tx"}, busy_lo, 0);
    cyc();
    check_eq({tag, "_done_pulse"}, {31'd0, (which == 1) ? done2_s : done_s}, 1);
    cyc();
    check_eq({tag, "_done_one_cycle"}, {31'd0, (which == 1) ? done2_s : done_s}, 0);
    check_eq({tag, "_idle_after"}, {31'd0, (which == 1) ? busy2_s : busy_s}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_tx, bad_busy;
    rst_n = 1'b0; rst2_n = 1'b0;
    fifo_valid2 = 1'b1; fifo_data2 = 8'h19;
    pops = 0; last_wait = 0;
    fifo_q.push_back(8'h19); fifo_q.push_back(8'h80);
    drive_fifo();
    #23;
    check_eq("rst_tx", {31'd0, tx}, 1);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_ext", {31'd0, ext}, 0);
    check_eq("rst2_tx", {31'd0, tx2}, 1);

    // Basic packet 0x19, 0x80.
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    check_eq("idle_after_rst_busy", {31'd0, busy_s}, 0);
    check_eq("idle_after_rst_ext", {31'd0, ext_s}, 0);
    cyc();
    check_eq("fetch_int_1cyc", {31'd0, ext_s}, 1);
    recv_pkt("basic", 0, 4, 8'hA5, 8'h19, 8'h80, 8'h3C);
    check_eq("basic_start_latency", last_wait, 2);
    check_eq("basic_pops", pops, 2);

    // 50-cycle FIFO starvation between INT and FRAC.
    pops = 0;
    fifo_q.push_back(8'h19);
    drive_fifo();
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (tx_s !== 1'b1) bad_tx++;
      if (busy_s !== 1'b1) bad_busy++;
    end
    check_eq("gap_tx_high", bad_tx, 0);
    check_eq("gap_busy", bad_busy, 0);
    check_eq("gap_pops_mid", pops, 1);
    fifo_q.push_back(8'h80);
    drive_fifo();
    recv_pkt("gap", 0, 4, 8'hA5, 8'h19, 8'h80, 8'h3C);
    check_eq("gap_start_latency", last_wait, 2);
    check_eq("gap_pops", pops, 2);

    // Four preloaded bytes -> two back-to-back packets.
    pops = 0;
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03); fifo_q.push_back(8'h04);
    drive_fifo();
    recv_pkt("b2b_1", 0, 4, 8'hA5, 8'h01, 8'h02, 8'hA6);
    recv_pkt("b2b_2", 0, 4, 8'hA5, 8'h03, 8'h04, 8'hA2);
    check_eq("b2b_pops", pops, 4);

    // Reset during data bit 0 of the INT byte (INT = 0x00, so the line is low).
    fifo_q.push_back(8'h00); fifo_q.push_back(8'h00);
    drive_fifo();
    last_wait = 0;
    do begin
      cyc();
      last_wait++;
    end while (tx_s !== 1'b0 && last_wait < 200);
    check_eq("abort_start_seen", {31'd0, tx_s}, 0);
    for (int i = 0; i < 45; i++) cyc();
    check_eq("abort_pre_tx", {31'd0, tx}, 0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_tx_async", {31'd0, tx}, 1);
    check_eq("abort_busy_async", {31'd0, busy}, 0);
    check_eq("abort_done_async", {31'd0, done}, 0);
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 1'b1;
    pops = 0;
    fifo_q.push_back(8'h00); fifo_q.push_back(8'h00);
    drive_fifo();
    recv_pkt("after_abort", 0, 4, 8'hA5, 8'h00, 8'h00, 8'hA5);
    check_eq("after_abort_pops", pops, 2);

    // CLKS_PER_BIT=2 instance, FIFO always offering 0x19.
    rst2_n = 1'b1;
    recv_pkt("cpb2", 1, 2, 8'hA5, 8'h19, 8'h19, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
